// File: rtl/apb_master.sv
// APB requester: accepts one valid/ready command, runs the APB SETUP/ACCESS phases
// and returns read data plus an error flag (pslverr or ACCESS timeout).
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  // A 1-bit counter is kept when TIMEOUT is 0 so the vector never collapses to zero width.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [CNT_W:0]      cnt_inc;
  logic                psel_n, penable_n, pwrite_n;
  logic [ADDR_W-1:0]   paddr_n;
  logic [DATA_W-1:0]   pwdata_n;
  logic                rsp_valid_n, rsp_err_n;
  logic [DATA_W-1:0]   rsp_rdata_n;

  assign cmd_ready = (state == IDLE);
  assign cnt_inc   = {1'b0, cnt} + 1'b1;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= IDLE;
      cnt       <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      psel      <= psel_n;
      penable   <= penable_n;
      pwrite    <= pwrite_n;
      paddr     <= paddr_n;
      pwdata    <= pwdata_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err   <= rsp_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    psel_n      = psel;
    penable_n   = penable;
    pwrite_n    = pwrite;
    paddr_n     = paddr;
    pwdata_n    = pwdata;
    rsp_valid_n = rsp_valid;
    rsp_rdata_n = rsp_rdata;
    rsp_err_n   = rsp_err;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_n  = cmd_write;
          paddr_n   = cmd_addr;
          pwdata_n  = cmd_write ? cmd_wdata : '0;
          psel_n    = 1'b1;
          penable_n = 1'b0;
          state_n   = SETUP;
        end
      end

      SETUP: begin
        penable_n = 1'b1;
        cnt_n     = '0;
        state_n   = ACCESS;
      end

      ACCESS: begin
        if (pready) begin
          rsp_err_n   = pslverr;
          rsp_rdata_n = (!pwrite && !pslverr) ? prdata : '0;
          psel_n      = 1'b0;
          penable_n   = 1'b0;
          rsp_valid_n = 1'b1;
          state_n     = RESP;
        end else begin
          cnt_n = (cnt == '1) ? cnt : cnt_inc[CNT_W-1:0];
          // cnt_inc equals the number of ACCESS cycles spent so far including this one.
          if ((TIMEOUT != 0) && (cnt_inc == (CNT_W + 1)'(TIMEOUT))) begin
            rsp_err_n   = 1'b1;
            rsp_rdata_n = '0;
            psel_n      = 1'b0;
            penable_n   = 1'b0;
            rsp_valid_n = 1'b1;
            state_n     = RESP;
          end
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: a wait-state APB slave plus a transaction-level reference
// model (expected ACCESS length, error and read data) driving directed and random traffic.
module tb_apb_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          pclk, preset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr;

  int checks   = 0;
  int failures = 0;

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Completer: 64-word RAM, addresses >= 32 answer with pslverr,
  // pready after wait_n low ACCESS cycles unless stuck.
  logic [31:0] smem [64];
  int unsigned acc_cnt = 0;
  int unsigned wait_n  = 0;
  logic        stuck   = 1'b0;
  logic        slv_clear;

  assign pready  = psel && penable && !stuck && (acc_cnt >= wait_n);
  assign pslverr = pready && (paddr >= 32);
  assign prdata  = pready ? smem[paddr[5:0]] : 32'hA5A5_A5A5;

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (slv_clear) begin
      for (int i = 0; i < 64; i++) smem[i] <= '0;
    end else if (psel && penable && pready && pwrite && !pslverr) begin
      smem[paddr[5:0]] <= pwdata;
    end
  end

  logic [31:0] ref_mem [64];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input int unsigned waits, input bit stk, input int unsigned hold,
                        input bit junk);
    bit          completes;
    int unsigned exp_acc;
    bit          exp_err;
    logic [31:0] exp_rd;
    int unsigned n;

    completes = !stk && (waits < TO);
    exp_acc   = completes ? waits + 1 : TO;
    exp_err   = !completes || (addr >= 32);
    exp_rd    = (!wr && !exp_err) ? ref_mem[addr[5:0]] : 32'h0;
    if (wr && !exp_err) ref_mem[addr[5:0]] = data;

    @(negedge pclk);
    wait_n    = waits;
    stuck     = stk;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    rsp_ready = 1'($urandom % 2);
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);

    @(posedge pclk); #1;
    chk("setup_ctl", {psel, penable, pwrite, cmd_ready}, {1'b1, 1'b0, wr, 1'b0});
    chk("setup_addr", paddr, addr);
    chk("setup_wdata", pwdata, wr ? data : 32'h0);
    if (junk) begin
      cmd_addr  = ~addr;
      cmd_write = ~wr;
      cmd_wdata = $urandom;
    end else begin
      cmd_valid = 1'b0;
    end

    n = 0;
    do begin
      @(posedge pclk); #1;
      n++;
      if (!rsp_valid) begin
        chk("access_ctl", {psel, penable, pwrite, cmd_ready}, {1'b1, 1'b1, wr, 1'b0});
        chk("access_addr", paddr, addr);
        chk("access_wdata", pwdata, wr ? data : 32'h0);
      end
    end while (!rsp_valid && n < 40);

    chk("access_len", 64'(n), 64'(exp_acc + 1));
    chk("rsp_ctl", {rsp_valid, rsp_err, psel, penable, cmd_ready},
        {1'b1, exp_err, 1'b0, 1'b0, 1'b0});
    chk("rsp_rdata", rsp_rdata, exp_rd);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;

    repeat (hold) begin
      @(posedge pclk); #1;
      chk("hold_ctl", {rsp_valid, rsp_err, cmd_ready, psel}, {1'b1, exp_err, 1'b0, 1'b0});
      chk("hold_rdata", rsp_rdata, exp_rd);
    end

    rsp_ready = 1'b1;
    @(posedge pclk); #1;
    chk("retire", {rsp_valid, cmd_ready}, {1'b0, 1'b1});
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    preset    = 1'b1;
    slv_clear = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;

    repeat (3) @(posedge pclk);
    #1;
    chk("reset_ctl", {psel, penable, pwrite, rsp_valid, rsp_err, cmd_ready},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    chk("reset_data", {paddr, pwdata}, 64'h0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    @(negedge pclk);
    preset    = 1'b0;
    slv_clear = 1'b0;

    // zero-wait write, then read back the same word
    do_txn(1'b1, 32'd5, 32'hDEAD_BEEF, 0, 1'b0, 0, 1'b0);
    chk("slave_mem5", smem[5], 32'hDEAD_BEEF);
    do_txn(1'b0, 32'd5, 32'h0, 0, 1'b0, 0, 1'b0);

    // three wait states: completion lands on the last allowed ACCESS cycle
    do_txn(1'b1, 32'd7, 32'h0000_1234, 0, 1'b0, 0, 1'b0);
    do_txn(1'b0, 32'd7, 32'h0, 3, 1'b0, 0, 1'b0);

    do_txn(1'b0, 32'd40, 32'h0, 0, 1'b0, 0, 1'b0);

    // timeouts: stuck slave and one that would answer a cycle too late
    do_txn(1'b0, 32'd9, 32'h0, 0, 1'b1, 0, 1'b0);
    do_txn(1'b1, 32'd10, 32'h5555_AAAA, 4, 1'b0, 0, 1'b0);
    do_txn(1'b0, 32'd10, 32'h0, 0, 1'b0, 0, 1'b0);

    // consumer back-pressure with a competing command held on the input
    do_txn(1'b1, 32'd12, $urandom, 1, 1'b0, 5, 1'b1);
    do_txn(1'b0, 32'd12, 32'h0, 2, 1'b0, 5, 1'b1);

    // reset in the middle of ACCESS
    @(negedge pclk);
    stuck     = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'd3;
    cmd_wdata = 32'hCAFE_F00D;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    chk("mid_access", {psel, penable}, {1'b1, 1'b1});
    preset = 1'b1;
    #1;
    chk("mid_reset_ctl", {psel, penable, rsp_valid, cmd_ready}, {1'b0, 1'b0, 1'b0, 1'b1});
    chk("mid_reset_addr", paddr, 32'h0);
    @(negedge pclk);
    preset = 1'b0;
    stuck  = 1'b0;
    repeat (3) begin
      @(posedge pclk); #1;
      chk("post_reset_quiet", {rsp_valid, psel, cmd_ready}, {1'b0, 1'b0, 1'b1});
    end
    chk("abandoned_write", smem[3], 32'h0);
    do_txn(1'b0, 32'd3, 32'h0, 0, 1'b0, 0, 1'b0);
    do_txn(1'b0, 32'd5, 32'h0, 1, 1'b0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      do_txn(1'($urandom % 2), 32'($urandom % 48), $urandom, $urandom % 6,
             ($urandom % 8) == 0, $urandom % 3, 1'($urandom % 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
